// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write initiator between execute and the machine-mode CSR file.
// Latency: response 3 cycles after accept when a write happens, 2 cycles otherwise.
// Backpressure: one request in flight; req_ready low until the response handshake completes.
module csr_access_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstl,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_funct3,
   input  logic [11:0]     req_csr,
   input  logic [4:0]      req_rs1,
   input  logic [XLEN-1:0] req_rs1_val,
   input  logic [4:0]      req_rd,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic [4:0]      resp_rd,
   output logic            resp_rd_we,
   output logic            resp_illegal,
   output logic [11:0]     csr_addr,
   output logic            csr_w,
   output logic [XLEN-1:0] csr_din,
   input  logic [XLEN-1:0] csr_dout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   // Latched request context: operation kind (funct3[1:0]), operand, and pre-decoded flags.
   logic [1:0]      kind;
   logic [XLEN-1:0] operand;
   logic            write_needed;
   logic            illegal;

   // Decode of the incoming request, used only at the accept edge.
   logic            acc_write_needed;
   logic            acc_illegal;
   logic [XLEN-1:0] acc_operand;

   logic [XLEN-1:0] new_val;

   // Decode the offered request: immediate forms use the zero-extended rs1 field as operand.
   always_comb begin
      acc_write_needed = (req_funct3[1:0] == 2'b01) || (req_rs1 != 5'd0);
      acc_illegal      = (req_funct3[1:0] == 2'b00) ||
                         (acc_write_needed && (req_csr[11:10] == 2'b11));
      acc_operand      = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1} : req_rs1_val;
   end

   // Compute the replacement value from the CSR contents read this cycle.
   always_comb begin
      case (kind)
         2'b01:   new_val = operand;
         2'b10:   new_val = csr_dout | operand;
         2'b11:   new_val = csr_dout & ~operand;
         default: new_val = operand;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstl) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: read always happens, write only when needed and legal.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = READ;
         READ:    state_nxt = (write_needed && !illegal) ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and write strobe; gated by rstl so a reset cycle in WRITE never writes.
   always_comb begin
      req_ready  = rstl && (state == IDLE);
      csr_w      = rstl && (state == WRITE);
      resp_valid = rstl && (state == RESP);
   end

   // Datapath: latch the request at accept, capture the old value and new value in READ.
   always_ff @(posedge clk) begin
      if (!rstl) begin
         kind         <= 2'b00;
         operand      <= '0;
         write_needed <= 1'b0;
         illegal      <= 1'b0;
         csr_addr     <= '0;
         csr_din      <= '0;
         resp_data    <= '0;
         resp_rd      <= '0;
         resp_rd_we   <= 1'b0;
         resp_illegal <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  kind         <= req_funct3[1:0];
                  operand      <= acc_operand;
                  write_needed <= acc_write_needed;
                  illegal      <= acc_illegal;
                  csr_addr     <= req_csr;
                  resp_rd      <= req_rd;
               end
            end
            READ: begin
               resp_data    <= illegal ? '0 : csr_dout;
               resp_illegal <= illegal;
               resp_rd_we   <= !illegal && (resp_rd != 5'd0);
               if (write_needed && !illegal) begin
                  csr_din <= new_val;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: directed test-plan cases plus random Zicsr traffic.
// Expected responses and CSR writes are queued by the driver and popped by a monitor.
// A behavioural CSR file (misa read-only, mepc bit 0 forced low) sits on the CSR port.
module tb_csr_access_unit;

   localparam int XLEN = 32;
   localparam logic [31:0] MISA_VAL = 32'h40000100;

   logic            clk;
   logic            rstl;
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_funct3;
   logic [11:0]     req_csr;
   logic [4:0]      req_rs1;
   logic [XLEN-1:0] req_rs1_val;
   logic [4:0]      req_rd;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_data;
   logic [4:0]      resp_rd;
   logic            resp_rd_we;
   logic            resp_illegal;
   logic [11:0]     csr_addr;
   logic            csr_w;
   logic [XLEN-1:0] csr_din;
   logic [XLEN-1:0] csr_dout;

   csr_access_unit #(.XLEN(XLEN)) dut (
      .clk          (clk),
      .rstl         (rstl),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_funct3   (req_funct3),
      .req_csr      (req_csr),
      .req_rs1      (req_rs1),
      .req_rs1_val  (req_rs1_val),
      .req_rd       (req_rd),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_rd      (resp_rd),
      .resp_rd_we   (resp_rd_we),
      .resp_illegal (resp_illegal),
      .csr_addr     (csr_addr),
      .csr_w        (csr_w),
      .csr_din      (csr_din),
      .csr_dout     (csr_dout)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
      int          c0;
      int          lat;
   } exp_t;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] din;
      int          cyc;
   } wexp_t;

   exp_t  expq[$];
   wexp_t wq[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rr_mode = 0;

   logic [31:0] file_mem [0:4095];
   logic [31:0] ref_csr  [0:4095];

   function automatic logic [31:0] init_val(input int i);
      if (i == 12'h340) return 32'h12345678;
      return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Reference view of a CSR read.
   function automatic logic [31:0] ref_read(input logic [11:0] a);
      if (a == 12'h301) return MISA_VAL;
      return ref_csr[a];
   endfunction

   // Reference view of a CSR write as the file applies it.
   function automatic void ref_write(input logic [11:0] a, input logic [31:0] v);
      if (a == 12'h301) return;
      if (a == 12'h341) ref_csr[a] = v & ~32'h1;
      else ref_csr[a] = v;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // CSR file: combinational read, write on the clock edge.
   assign csr_dout = (csr_addr == 12'h301) ? MISA_VAL : file_mem[csr_addr];

   initial begin
      for (int i = 0; i < 4096; i++) file_mem[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (csr_w) begin
            if (csr_addr == 12'h341) file_mem[csr_addr] = csr_din & ~32'h1;
            else if (csr_addr != 12'h301) file_mem[csr_addr] = csr_din;
         end
      end
   end

   // Response consumer: always ready, random, or stalled.
   initial begin
      resp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ($urandom_range(0, 2) != 0);
            default: resp_ready = 1'b0;
         endcase
      end
   end

   // Monitor: response scoreboard, hold stability, and CSR write checking.
   initial begin
      logic        held;
      logic        prev_valid;
      logic [31:0] h_data;
      logic [4:0]  h_rd;
      logic        h_we;
      logic        h_ill;
      exp_t        e;
      wexp_t       w;
      held = 1'b0;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (held) begin
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_data", resp_data, h_data);
            chk("hold_rd", 32'(resp_rd), 32'(h_rd));
            chk("hold_rd_we", 32'(resp_rd_we), 32'(h_we));
            chk("hold_illegal", 32'(resp_illegal), 32'(h_ill));
         end
         held = 1'b0;
         if (resp_valid) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected actual=valid required=none (t=%0t)", $time);
            end else begin
               e = expq[0];
               if (!prev_valid) chk("resp_latency", 32'(cyc - e.c0), 32'(e.lat));
               if (resp_ready) begin
                  void'(expq.pop_front());
                  chk("resp_data", resp_data, e.data);
                  chk("resp_rd", 32'(resp_rd), 32'(e.rd));
                  chk("resp_rd_we", 32'(resp_rd_we), 32'(e.we));
                  chk("resp_illegal", 32'(resp_illegal), 32'(e.ill));
               end else begin
                  held = 1'b1;
                  h_data = resp_data;
                  h_rd = resp_rd;
                  h_we = resp_rd_we;
                  h_ill = resp_illegal;
               end
            end
         end
         prev_valid = resp_valid;
         if (csr_w) begin
            if (wq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL csr_w_unexpected actual=addr %h din %h required=no write (t=%0t)",
                        csr_addr, csr_din, $time);
            end else begin
               w = wq.pop_front();
               chk("csr_w_cycle", 32'(cyc), 32'(w.cyc));
               chk("csr_w_addr", 32'(csr_addr), 32'(w.addr));
               chk("csr_w_din", csr_din, w.din);
            end
         end
      end
   end

   // Present one request, wait for acceptance, record expectations from the reference model.
   task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                        input logic [31:0] rv, input logic [4:0] rd);
      exp_t        e;
      wexp_t       w;
      int          n;
      logic        valid_f3;
      logic        wn;
      logic        ill;
      logic [31:0] op;
      logic [31:0] old;
      logic [31:0] nv;
      @(negedge clk);
      req_valid   = 1'b1;
      req_funct3  = f3;
      req_csr     = a;
      req_rs1     = rs1;
      req_rs1_val = rv;
      req_rd      = rd;
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=req_ready 0 required=1 (t=%0t)", $time);
         req_valid = 1'b0;
         return;
      end
      valid_f3 = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3) ||
                 (f3 == 3'd5) || (f3 == 3'd6) || (f3 == 3'd7);
      op  = (f3 >= 3'd4) ? {27'd0, rs1} : rv;
      wn  = (f3 == 3'd1) || (f3 == 3'd5) || (rs1 != 5'd0);
      ill = !valid_f3 || (wn && (a >= 12'hC00));
      old = ref_read(a);
      e.data = ill ? 32'd0 : old;
      e.rd   = rd;
      e.we   = !ill && (rd != 5'd0);
      e.ill  = ill;
      e.c0   = cyc;
      e.lat  = (wn && !ill) ? 3 : 2;
      expq.push_back(e);
      if (wn && !ill) begin
         if (f3 == 3'd1 || f3 == 3'd5) nv = op;
         else if (f3 == 3'd2 || f3 == 3'd6) nv = old | op;
         else nv = old & ~op;
         w.addr = a;
         w.din  = nv;
         w.cyc  = cyc + 2;
         wq.push_back(w);
         ref_write(a, nv);
      end
      @(posedge clk);
      #1;
      req_valid   = 1'b0;
      req_funct3  = 3'($urandom);
      req_csr     = 12'($urandom);
      req_rs1     = 5'($urandom);
      req_rs1_val = $urandom;
      req_rd      = 5'($urandom);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (expq.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_outstanding", 32'(expq.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] addrs [0:7];
      logic [31:0] saved;
      int n;
      addrs[0] = 12'h340; addrs[1] = 12'h341; addrs[2] = 12'h301; addrs[3] = 12'hF11;
      addrs[4] = 12'h305; addrs[5] = 12'h342; addrs[6] = 12'h7C0; addrs[7] = 12'hC00;
      for (int i = 0; i < 4096; i++) ref_csr[i] = init_val(i);
      rstl = 1'b0;
      req_valid = 1'b0;
      req_funct3 = 3'd0;
      req_csr = 12'd0;
      req_rs1 = 5'd0;
      req_rs1_val = 32'd0;
      req_rd = 5'd0;
      rr_mode = 0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_csr_w", 32'(csr_w), 32'd0);
      chk("rst_csr_addr", 32'(csr_addr), 32'd0);
      chk("rst_csr_din", csr_din, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_rd", 32'(resp_rd), 32'd0);
      chk("rst_resp_rd_we", 32'(resp_rd_we), 32'd0);
      chk("rst_resp_illegal", 32'(resp_illegal), 32'd0);
      @(posedge clk);
      #1 rstl = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);

      // CSRRW x5, mscratch; CSRRS x1, misa, x0; CSRRCI x2, mscratch, 0x0F; read back.
      issue(3'b001, 12'h340, 5'd7, 32'hDEADBEEF, 5'd5);
      issue(3'b010, 12'h301, 5'd0, 32'hFFFFFFFF, 5'd1);
      issue(3'b111, 12'h340, 5'h0F, 32'h0, 5'd2);
      issue(3'b010, 12'h340, 5'd0, 32'h0, 5'd4);
      wait_drain();
      chk("mscratch_after_rci", file_mem[12'h340], 32'hDEADBEE0);

      // Illegal: CSRRWI to read-only mvendorid, and funct3 = 100.
      issue(3'b101, 12'hF11, 5'd3, 32'h0, 5'd3);
      issue(3'b100, 12'h340, 5'd1, 32'h1234, 5'd3);

      // CSRRW x0, mepc, with the response stalled for 3 cycles.
      wait_drain();
      rr_mode = 2;
      issue(3'b001, 12'h341, 5'd9, 32'h00001003, 5'd0);
      n = 0;
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_resp_seen", 32'(resp_valid), 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("bp_req_ready_low", 32'(req_ready), 32'd0);
      end
      rr_mode = 0;
      wait_drain();
      chk("mepc_after_write", file_mem[12'h341], 32'h00001002);
      issue(3'b010, 12'h341, 5'd0, 32'h0, 5'd6);
      wait_drain();

      // Reset during the WRITE cycle of a CSRRW to mscratch.
      saved = ref_read(12'h340);
      @(negedge clk);
      req_valid = 1'b1;
      req_funct3 = 3'b001;
      req_csr = 12'h340;
      req_rs1 = 5'd7;
      req_rs1_val = 32'h55AA55AA;
      req_rd = 5'd9;
      chk("abort_accept_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 rstl = 1'b0;
      @(negedge clk);
      chk("abort_csr_w", 32'(csr_w), 32'd0);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("abort_resp_valid_after", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1 rstl = 1'b1;
      @(negedge clk);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_mscratch", file_mem[12'h340], saved);

      // Random traffic with random backpressure and stale inputs after accept.
      for (int t = 0; t < 200; t++) begin
         if (t % 25 == 0) rr_mode = $urandom_range(0, 1);
         issue(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 7)],
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom, 5'($urandom_range(0, 31)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rr_mode = 0;
      wait_drain();
      repeat (4) @(negedge clk);
      chk("writes_outstanding", 32'(wq.size()), 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("final_csr_state", file_mem[addrs[i]], ref_read(addrs[i]) &
             ((addrs[i] == 12'h301) ? 32'h0 : 32'hFFFFFFFF) |
             ((addrs[i] == 12'h301) ? file_mem[addrs[i]] : 32'h0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
